// File: rtl/cursor_square_select.sv
// Cursor-to-square mapping, button debounce and two-click source/destination select with a
// held move request. Optional macro RIGHT_CANCEL_EN adds a debounced right button that cancels a selection.
module cursor_square_select #(
    parameter int BOARD_X0   = 80,
    parameter int BOARD_Y0   = 0,
    parameter int SQ_SIZE    = 60,
    parameter int DEB_FRAMES = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [9:0] cursor_x,
    input  logic [9:0] cursor_y,
    input  logic       btn_left,
`ifdef RIGHT_CANCEL_EN
    input  logic       btn_right,
`endif
    input  logic       move_ack,
    output logic       hover_valid,
    output logic [5:0] hover_sq,
    output logic       sel_valid,
    output logic [5:0] sel_sq,
    output logic       move_valid,
    output logic [5:0] move_src,
    output logic [5:0] move_dst
);

    // state   | meaning
    // IDLE    | nothing selected, waiting for a source click
    // SRC     | source square held in sel_sq, waiting for a destination click
    // PEND    | move request presented, waiting for move_ack
    typedef enum logic [1:0] {ST_IDLE, ST_SRC, ST_PEND} state_t;

    localparam logic [10:0] BOARD_SPAN = 11'(8 * SQ_SIZE);
    localparam logic [3:0]  DEB_LAST   = 4'(DEB_FRAMES - 1);

    state_t state;

    function automatic logic [2:0] sq_index(input logic [10:0] d);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (d >= 11'(k * SQ_SIZE))
                n = n + 3'd1;
        end
        return n;
    endfunction

    logic [10:0] dx, dy;
    logic        on_board;

    // Bit 10 of the 11-bit difference flags a cursor left of / above the board origin.
    assign dx       = {1'b0, cursor_x} - 11'(BOARD_X0);
    assign dy       = {1'b0, cursor_y} - 11'(BOARD_Y0);
    assign on_board = !dx[10] && (dx < BOARD_SPAN) && !dy[10] && (dy < BOARD_SPAN);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hover_valid <= 1'b0;
            hover_sq    <= 6'd0;
        end else begin
            hover_valid <= on_board;
            if (on_board)
                hover_sq <= {sq_index(dy), sq_index(dx)};
        end
    end

    logic       btn_db_l;
    logic [3:0] cnt_l;
    logic       click_l;

    assign click_l = btn_left && !btn_db_l && (cnt_l == DEB_LAST);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            btn_db_l <= 1'b0;
            cnt_l    <= 4'd0;
        end else if (btn_left != btn_db_l) begin
            if (cnt_l == DEB_LAST) begin
                btn_db_l <= btn_left;
                cnt_l    <= 4'd0;
            end else begin
                cnt_l <= cnt_l + 4'd1;
            end
        end else begin
            cnt_l <= 4'd0;
        end
    end

    logic cancel;

`ifdef RIGHT_CANCEL_EN
    logic       btn_db_r;
    logic [3:0] cnt_r;

    assign cancel = btn_right && !btn_db_r && (cnt_r == DEB_LAST);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            btn_db_r <= 1'b0;
            cnt_r    <= 4'd0;
        end else if (btn_right != btn_db_r) begin
            if (cnt_r == DEB_LAST) begin
                btn_db_r <= btn_right;
                cnt_r    <= 4'd0;
            end else begin
                cnt_r <= cnt_r + 4'd1;
            end
        end else begin
            cnt_r <= 4'd0;
        end
    end
`else
    assign cancel = 1'b0;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            sel_valid  <= 1'b0;
            sel_sq     <= 6'd0;
            move_valid <= 1'b0;
            move_src   <= 6'd0;
            move_dst   <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (click_l && hover_valid) begin
                        state     <= ST_SRC;
                        sel_sq    <= hover_sq;
                        sel_valid <= 1'b1;
                    end
                end
                ST_SRC: begin
                    // A cancel press outranks a simultaneous left click.
                    if (cancel) begin
                        state     <= ST_IDLE;
                        sel_valid <= 1'b0;
                    end else if (click_l) begin
                        if (hover_valid && (hover_sq != sel_sq)) begin
                            state      <= ST_PEND;
                            move_src   <= sel_sq;
                            move_dst   <= hover_sq;
                            move_valid <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            sel_valid <= 1'b0;
                        end
                    end
                end
                ST_PEND: begin
                    if (move_ack) begin
                        state      <= ST_IDLE;
                        move_valid <= 1'b0;
                        sel_valid  <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    sel_valid  <= 1'b0;
                    move_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_square_select.sv
// Directed bench for cursor_square_select: square mapping, debounce, select/move/ack flow, reset.
module tb_cursor_square_select;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [9:0] cursor_x, cursor_y;
    logic       btn_left, move_ack;
`ifdef RIGHT_CANCEL_EN
    logic       btn_right;
`endif
    logic       hover_valid, sel_valid, move_valid;
    logic [5:0] hover_sq, sel_sq, move_src, move_dst;

    int vectors = 0;
    int errors  = 0;

    always #5 frame_clk = ~frame_clk;

    cursor_square_select dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .btn_left   (btn_left),
`ifdef RIGHT_CANCEL_EN
        .btn_right  (btn_right),
`endif
        .move_ack   (move_ack),
        .hover_valid(hover_valid),
        .hover_sq   (hover_sq),
        .sel_valid  (sel_valid),
        .sel_sq     (sel_sq),
        .move_valid (move_valid),
        .move_src   (move_src),
        .move_dst   (move_dst)
    );

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_cursor(input int x, input int y);
        cursor_x = 10'(x);
        cursor_y = 10'(y);
    endtask

    // Full debounced press and release; the click lands on the 3rd edge of the press.
    task automatic click(input int x, input int y);
        set_cursor(x, y);
        btn_left = 1'b1;
        repeat (3) tick();
        btn_left = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #2;
        vectors++;
        if ({hover_valid, hover_sq, sel_valid, sel_sq, move_valid, move_src, move_dst} !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {hover_valid, hover_sq, sel_valid, sel_sq, move_valid, move_src, move_dst});
        end
        set_cursor(85, 5);
        repeat (2) tick();
        vectors++;
        if (hover_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_hover: got %b expected 0", hover_valid);
        end
        Reset = 1'b0;
    endtask

    task automatic test_hover();
        int xs[6] = '{85, 559, 560, 79, 80, 140};
        int ys[6] = '{5, 479, 100, 10, 0, 60};
        logic       ev[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [5:0] es[6] = '{6'd0, 6'd63, 6'd63, 6'd63, 6'd0, 6'd9};
        for (int i = 0; i < 6; i++) begin
            set_cursor(xs[i], ys[i]);
            tick();
            vectors++;
            if (hover_valid !== ev[i] || hover_sq !== es[i]) begin
                errors++;
                $display("FAIL hover_%0d: got valid=%b sq=%0d expected valid=%b sq=%0d",
                         i, hover_valid, hover_sq, ev[i], es[i]);
            end
        end
    endtask

    task automatic test_debounce();
        set_cursor(230, 90);
        btn_left = 1'b1;
        repeat (2) tick();
        btn_left = 1'b0;
        repeat (2) tick();
        vectors++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL deb_glitch: got sel_valid=%b expected 0", sel_valid);
        end
        btn_left = 1'b1;
        repeat (2) tick();
        vectors++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL deb_early: got sel_valid=%b expected 0 after 2 edges", sel_valid);
        end
        tick();
        vectors++;
        if (sel_valid !== 1'b1 || sel_sq !== 6'd10) begin
            errors++;
            $display("FAIL deb_accept: got valid=%b sq=%0d expected valid=1 sq=10", sel_valid, sel_sq);
        end
        btn_left = 1'b0;
        repeat (3) tick();
        vectors++;
        if (sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL deb_release: got sel_valid=%b expected 1", sel_valid);
        end
        click(230, 90);
    endtask

    task automatic test_move_ack();
        click(350, 90);
        vectors++;
        if (sel_valid !== 1'b1 || sel_sq !== 6'd12) begin
            errors++;
            $display("FAIL move_src_sel: got valid=%b sq=%0d expected valid=1 sq=12", sel_valid, sel_sq);
        end
        click(350, 210);
        vectors++;
        if (move_valid !== 1'b1 || move_src !== 6'd12 || move_dst !== 6'd28) begin
            errors++;
            $display("FAIL move_req: got v=%b src=%0d dst=%0d expected v=1 src=12 dst=28",
                     move_valid, move_src, move_dst);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (move_valid !== 1'b1 || move_src !== 6'd12 || move_dst !== 6'd28 || sel_valid !== 1'b1) begin
                errors++;
                $display("FAIL move_hold_%0d: got v=%b src=%0d dst=%0d sel=%b expected 1/12/28/1",
                         i, move_valid, move_src, move_dst, sel_valid);
            end
        end
        click(110, 330);
        vectors++;
        if (move_valid !== 1'b1 || move_dst !== 6'd28) begin
            errors++;
            $display("FAIL pend_click: got v=%b dst=%0d expected v=1 dst=28", move_valid, move_dst);
        end
        move_ack = 1'b1;
        tick();
        move_ack = 1'b0;
        vectors++;
        if (move_valid !== 1'b0 || sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack: got move_valid=%b sel_valid=%b expected 0 0", move_valid, sel_valid);
        end
    endtask

    task automatic test_deselect();
        click(20, 20);
        vectors++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_offboard: got sel_valid=%b expected 0", sel_valid);
        end
        click(350, 90);
        click(350, 90);
        vectors++;
        if (sel_valid !== 1'b0 || move_valid !== 1'b0) begin
            errors++;
            $display("FAIL deselect_same: got sel=%b move=%b expected 0 0", sel_valid, move_valid);
        end
        click(350, 90);
        click(20, 20);
        vectors++;
        if (sel_valid !== 1'b0 || move_valid !== 1'b0) begin
            errors++;
            $display("FAIL deselect_off: got sel=%b move=%b expected 0 0", sel_valid, move_valid);
        end
    endtask

    task automatic test_reset_in_pend();
        move_ack = 1'b1;
        click(350, 90);
        vectors++;
        if (sel_valid !== 1'b1 || move_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_in_src: got sel=%b move=%b expected 1 0", sel_valid, move_valid);
        end
        move_ack = 1'b0;
        click(350, 210);
        vectors++;
        if (move_valid !== 1'b1) begin
            errors++;
            $display("FAIL pend_again: got move_valid=%b expected 1", move_valid);
        end
        #2;
        Reset = 1'b1;
        #1;
        vectors++;
        if ({hover_valid, hover_sq, sel_valid, sel_sq, move_valid, move_src, move_dst} !== 27'd0) begin
            errors++;
            $display("FAIL reset_pend: got %b expected all zero",
                     {hover_valid, hover_sq, sel_valid, sel_sq, move_valid, move_src, move_dst});
        end
        tick();
        Reset = 1'b0;
        tick();
    endtask

`ifdef RIGHT_CANCEL_EN
    task automatic test_right_cancel();
        click(410, 30);
        vectors++;
        if (sel_valid !== 1'b1 || sel_sq !== 6'd5) begin
            errors++;
            $display("FAIL rc_select: got valid=%b sq=%0d expected 1 5", sel_valid, sel_sq);
        end
        btn_right = 1'b1;
        repeat (3) tick();
        vectors++;
        if (sel_valid !== 1'b0) begin
            errors++;
            $display("FAIL rc_cancel: got sel_valid=%b expected 0", sel_valid);
        end
        btn_right = 1'b0;
        repeat (3) tick();
        click(410, 30);
        set_cursor(350, 90);
        btn_left  = 1'b1;
        btn_right = 1'b1;
        repeat (3) tick();
        vectors++;
        if (sel_valid !== 1'b0 || move_valid !== 1'b0) begin
            errors++;
            $display("FAIL rc_tie: got sel=%b move=%b expected 0 0", sel_valid, move_valid);
        end
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (3) tick();
    endtask
`endif

    initial begin
        Reset    = 1'b1;
        cursor_x = 10'd0;
        cursor_y = 10'd0;
        btn_left = 1'b0;
        move_ack = 1'b0;
`ifdef RIGHT_CANCEL_EN
        btn_right = 1'b0;
`endif
        test_reset();
        test_hover();
        test_debounce();
        test_move_ack();
        test_deselect();
        test_reset_in_pend();
`ifdef RIGHT_CANCEL_EN
        test_right_cancel();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
